lfsr_rand_gen: RTL and testbench

Parametrised Fibonacci LFSR random-index generator, the successor to the fixed 15-bit word-bank LFSR.
- Generalised width, tap mask, seed and output window; adds runtime seed load, zero-lockup protection and a request/ack handshake.
- Returns an index uniformly below LIMIT by rejection sampling, bounded by MAX_TRIES.
- Feeds ROM word-bank address logic and any game logic needing a random index.

---
 rtl/lfsr_rand_pkg.sv | 22 ++
 rtl/lfsr_rand_gen_core.sv | 46 ++++
 rtl/lfsr_rand_gen.sv | 174 +++++++++++++++++
 tb/tb_lfsr_rand_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rand_pkg.sv
// Shared types, default tap masks and the LFSR step function for the random-index generator.
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } fsm_e;

  // Maximal-length Fibonacci tap masks; bit i set feeds state[i] into the XOR.
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [14:0] TAPS_W15 = 15'h6000;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Callers zero-extend to 64 bits and keep the low WIDTH bits of the result.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps);
    return {state[62:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_core.sv
// LFSR state register: seed load, zero-lockup guard and conditional step.
module lfsr_core
  import lfsr_rand_pkg::*;
#(
  parameter int unsigned      WIDTH = 15,
  parameter logic [WIDTH-1:0] TAPS  = 15'h6000,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] next_s;

  // Seed load beats the zero guard, which beats a normal step.
  always_comb begin
    next_s  = WIDTH'(lfsr_next(64'(state_q), 64'(TAPS)));
    state_d = state_q;
    if (load_i) begin
      state_d = (load_val_i == {WIDTH{1'b0}}) ? SEED : load_val_i;
    end else if (state_q == {WIDTH{1'b0}}) begin
      state_d = SEED;
    end else if (adv_i) begin
      state_d = next_s;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Random-index generator: LFSR plus rejection-sampling request/ack FSM.
// Optional LFSR_PERIOD_CNT_EN adds period_cnt / period_wrap outputs.
module lfsr_rand_gen
  import lfsr_rand_pkg::*;
#(
  parameter int unsigned      WIDTH     = 15,
  parameter logic [WIDTH-1:0] TAPS      = 15'h6000,
  parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
  parameter int unsigned      OUT_W     = 5,
  parameter int unsigned      OUT_LSB   = 1,
  parameter int unsigned      LIMIT     = 32,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_req,
  input  logic             rnd_ack,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_out,
  output logic             rnd_fallback,
  output logic             busy,
`ifdef LFSR_PERIOD_CNT_EN
  output logic [WIDTH-1:0] period_cnt,
  output logic             period_wrap,
`endif
  output logic [WIDTH-1:0] state_q
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  fsm_e             fsm_q, fsm_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             fb_q, fb_d;
  logic             busy_q;
  logic             advance_s;
  logic             accept_s;
  logic [OUT_W-1:0] cand_s;

  assign advance_s = step_en | (fsm_q == SEARCH);
  assign cand_s    = state_q[OUT_LSB +: OUT_W];

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .adv_i      (advance_s),
    .load_i     (seed_load),
    .load_val_i (seed_in),
    .state_o    (state_q)
  );

  // A full-range LIMIT accepts every candidate, so no comparator is built.
  if (LIMIT >= (1 << OUT_W)) begin : g_accept_all
    assign accept_s = 1'b1;
  end else begin : g_accept_cmp
    localparam logic [OUT_W:0] LIMIT_C = (OUT_W + 1)'(LIMIT);
    assign accept_s = ({1'b0, cand_s} < LIMIT_C);
  end

  always_comb begin
    fsm_d   = fsm_q;
    try_d   = try_q;
    valid_d = valid_q;
    out_d   = out_q;
    fb_d    = fb_q;
    if (seed_load) begin
      fsm_d   = IDLE;
      valid_d = 1'b0;
      fb_d    = 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (rnd_req) begin
            fsm_d = SEARCH;
            try_d = TRY_W'(0);
          end else begin
            fsm_d = IDLE;
          end
        end
        SEARCH: begin
          if (accept_s) begin
            out_d   = cand_s;
            valid_d = 1'b1;
            fb_d    = 1'b0;
            fsm_d   = HOLD;
          end else if (try_q == TRY_W'(MAX_TRIES - 1)) begin
            out_d   = {OUT_W{1'b0}};
            valid_d = 1'b1;
            fb_d    = 1'b1;
            fsm_d   = HOLD;
          end else begin
            try_d = try_q + TRY_W'(1);
          end
        end
        HOLD: begin
          if (rnd_ack) begin
            valid_d = 1'b0;
            fb_d    = 1'b0;
            fsm_d   = IDLE;
          end else begin
            fsm_d = HOLD;
          end
        end
        default: begin
          fsm_d   = IDLE;
          valid_d = 1'b0;
          fb_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      try_q   <= TRY_W'(0);
      valid_q <= 1'b0;
      out_q   <= {OUT_W{1'b0}};
      fb_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      try_q   <= try_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      fb_q    <= fb_d;
      busy_q  <= (fsm_d == SEARCH);
    end
  end

  assign rnd_valid    = valid_q;
  assign rnd_out      = out_q;
  assign rnd_fallback = fb_q;
  assign busy         = busy_q;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] seed_ref_q;
  logic [WIDTH-1:0] pcnt_q;
  logic             pwrap_q;
  logic [WIDTH-1:0] nxt_s;
  logic             adv_eff_s;

  // Only real steps count; loads and the zero guard restart or bypass the count.
  assign nxt_s     = WIDTH'(lfsr_next(64'(state_q), 64'(TAPS)));
  assign adv_eff_s = advance_s & ~seed_load & (state_q != {WIDTH{1'b0}});

  always_ff @(posedge clock) begin
    if (!reset) begin
      seed_ref_q <= SEED;
      pcnt_q     <= {WIDTH{1'b0}};
      pwrap_q    <= 1'b0;
    end else if (seed_load) begin
      seed_ref_q <= (seed_in == {WIDTH{1'b0}}) ? SEED : seed_in;
      pcnt_q     <= {WIDTH{1'b0}};
      pwrap_q    <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_q + WIDTH'(adv_eff_s);
      pwrap_q    <= adv_eff_s & (nxt_s == seed_ref_q);
    end
  end

  assign period_cnt  = pcnt_q;
  assign period_wrap = pwrap_q;
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: default, LIMIT=31, LIMIT=1/MAX_TRIES=4 and a 4-bit LFSR.
module tb_lfsr_rand_gen;

  logic        clock;
  logic        reset;
  logic        step_en;
  logic        seed_load;
  logic [14:0] seed_in;
  logic        rnd_req;
  logic        rnd_ack;
  logic        w4_step;

  logic        v_def, v_l31, v_l1, v_w4;
  logic [4:0]  o_def, o_l31, o_l1;
  logic [1:0]  o_w4;
  logic        f_def, f_l31, f_l1, f_w4;
  logic        b_def, b_l31, b_l1, b_w4;
  logic [14:0] s_def, s_l31, s_l1;
  logic [3:0]  s_w4;
`ifdef LFSR_PERIOD_CNT_EN
  logic [14:0] pc_def, pc_l31, pc_l1;
  logic        pw_def, pw_l31, pw_l1, pw_w4;
  logic [3:0]  pc_w4;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  lfsr_rand_gen u_def (
    .clock(clock), .reset(reset), .step_en(step_en), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_req(rnd_req), .rnd_ack(rnd_ack),
    .rnd_valid(v_def), .rnd_out(o_def), .rnd_fallback(f_def), .busy(b_def),
`ifdef LFSR_PERIOD_CNT_EN
    .period_cnt(pc_def), .period_wrap(pw_def),
`endif
    .state_q(s_def)
  );

  lfsr_rand_gen #(.LIMIT(31)) u_l31 (
    .clock(clock), .reset(reset), .step_en(step_en), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_req(rnd_req), .rnd_ack(rnd_ack),
    .rnd_valid(v_l31), .rnd_out(o_l31), .rnd_fallback(f_l31), .busy(b_l31),
`ifdef LFSR_PERIOD_CNT_EN
    .period_cnt(pc_l31), .period_wrap(pw_l31),
`endif
    .state_q(s_l31)
  );

  lfsr_rand_gen #(.LIMIT(1), .MAX_TRIES(4)) u_l1 (
    .clock(clock), .reset(reset), .step_en(step_en), .seed_load(seed_load),
    .seed_in(seed_in), .rnd_req(rnd_req), .rnd_ack(rnd_ack),
    .rnd_valid(v_l1), .rnd_out(o_l1), .rnd_fallback(f_l1), .busy(b_l1),
`ifdef LFSR_PERIOD_CNT_EN
    .period_cnt(pc_l1), .period_wrap(pw_l1),
`endif
    .state_q(s_l1)
  );

  lfsr_rand_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'hF), .OUT_W(2), .OUT_LSB(1),
                  .LIMIT(4), .MAX_TRIES(2)) u_w4 (
    .clock(clock), .reset(reset), .step_en(w4_step), .seed_load(1'b0),
    .seed_in(4'h0), .rnd_req(1'b0), .rnd_ack(1'b0),
    .rnd_valid(v_w4), .rnd_out(o_w4), .rnd_fallback(f_w4), .busy(b_w4),
`ifdef LFSR_PERIOD_CNT_EN
    .period_cnt(pc_w4), .period_wrap(pw_w4),
`endif
    .state_q(s_w4)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; step_en = 1'b0; seed_load = 1'b0; seed_in = 15'h0;
    rnd_req = 1'b0; rnd_ack = 1'b0; w4_step = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(s_def), 32'h7FFF);
    check("rst_valid", 32'(v_def), 32'h0);
    check("rst_out",   32'(o_def), 32'h0);
    check("rst_fb",    32'(f_def), 32'h0);
    check("rst_busy",  32'(b_def), 32'h0);
    check("rst_w4",    32'(s_w4),  32'hF);

    // Edge 1: request sampled in IDLE.
    reset = 1'b1;
    rnd_req = 1'b1;
    tick();
    rnd_req = 1'b0;
    check("e1_busy",   32'(b_def), 32'h1);
    check("e1_valid",  32'(v_def), 32'h0);
    // Edge 2: first candidate 0x1F judged.
    tick();
    check("def_valid", 32'(v_def), 32'h1);
    check("def_out",   32'(o_def), 32'h1F);
    check("def_fb",    32'(f_def), 32'h0);
    check("def_state", 32'(s_def), 32'h7FFE);
    check("def_busy",  32'(b_def), 32'h0);
    check("l31_e2",    32'(v_l31), 32'h0);
    tick();
    check("l31_e3",    32'(v_l31), 32'h0);
    tick();
    check("l31_valid", 32'(v_l31), 32'h1);
    check("l31_out",   32'(o_l31), 32'h1E);
    check("l31_state", 32'(s_l31), 32'h7FF8);
    check("l1_e4",     32'(v_l1),  32'h0);
    tick();
    check("l1_valid",  32'(v_l1),  32'h1);
    check("l1_out",    32'(o_l1),  32'h0);
    check("l1_fb",     32'(f_l1),  32'h1);
    check("l1_state",  32'(s_l1),  32'h7FF0);
    check("def_hold_state", 32'(s_def), 32'h7FFE);

    // Request in HOLD is ignored.
    rnd_req = 1'b1;
    tick();
    rnd_req = 1'b0;
    check("hold_req_busy",  32'(b_def), 32'h0);
    check("hold_req_valid", 32'(v_def), 32'h1);
    check("hold_req_state", 32'(s_def), 32'h7FFE);

    // Ten free-run steps in HOLD.
    step_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_out",   32'(o_def), 32'h1F);
      check("hold_valid", 32'(v_def), 32'h1);
    end
    step_en = 1'b0;
    check("hold10_def", 32'(s_def), 32'h7800);
    check("hold10_l31", 32'(s_l31), 32'h6000);
    check("hold10_l1",  32'(s_l1),  32'h4000);

    rnd_ack = 1'b1;
    tick();
    rnd_ack = 1'b0;
    check("ack_valid", 32'(v_def), 32'h0);
    check("ack_out",   32'(o_def), 32'h1F);
    check("ack_state", 32'(s_def), 32'h7800);
    check("ack_l1_fb", 32'(f_l1),  32'h0);

    // Zero seed load while in SEARCH.
    rnd_req = 1'b1;
    tick();
    rnd_req = 1'b0;
    check("srch_busy", 32'(b_def), 32'h1);
    seed_load = 1'b1; seed_in = 15'h0;
    tick();
    check("sl0_state", 32'(s_def), 32'h7FFF);
    check("sl0_valid", 32'(v_def), 32'h0);
    check("sl0_busy",  32'(b_def), 32'h0);
    check("sl0_out",   32'(o_def), 32'h1F);
    seed_in = 15'h1234;
    tick();
    seed_load = 1'b0;
    check("sl_state",  32'(s_def), 32'h1234);
    step_en = 1'b1;
    tick();
    step_en = 1'b0;
    check("step_1234", 32'(s_def), 32'h2468);

    rnd_req = 1'b1;
    tick();
    rnd_req = 1'b0;
    tick();
    check("r2_valid", 32'(v_def), 32'h1);
    check("r2_out",   32'(o_def), 32'h14);
    check("r2_state", 32'(s_def), 32'h48D1);

    // seed_load and rnd_ack together in HOLD.
    seed_load = 1'b1; seed_in = 15'h0ABC; rnd_ack = 1'b1;
    tick();
    seed_load = 1'b0; rnd_ack = 1'b0;
    check("sla_state", 32'(s_def), 32'h0ABC);
    check("sla_valid", 32'(v_def), 32'h0);
    check("sla_fb",    32'(f_def), 32'h0);
    check("sla_out",   32'(o_def), 32'h14);
    tick();
    check("sla_idle",  32'(s_def), 32'h0ABC);

    // 4-bit LFSR: full period of 15, never zero.
    w4_step = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("w4_nonzero", 32'(s_w4 == 4'h0), 32'h0);
      if (i == 3) check("w4_step3", 32'(s_w4), 32'h8);
      if (i == 7) check("w4_step7", 32'(s_w4), 32'h9);
      if (i < 15) check("w4_not_seed", 32'(s_w4 == 4'hF), 32'h0);
`ifdef LFSR_PERIOD_CNT_EN
      check("w4_wrap", 32'(pw_w4), (i == 15) ? 32'h1 : 32'h0);
`endif
    end
    w4_step = 1'b0;
    check("w4_period", 32'(s_w4), 32'hF);
`ifdef LFSR_PERIOD_CNT_EN
    check("w4_pcnt", 32'(pc_w4), 32'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
